sifh_peak_scan: RTL and testbench
=================================

// Module: sifh_peak_scan
// PURPOSE
//  Downstream stage of the SiFH histogram builder. Once a frame's histograms are
//  accumulated in the dual-port histogram RAM, this block sweeps every pixel's bins.
//  It finds the peak bin (time-of-flight estimate) and its count, and reports one
//  result per pixel over a valid/ready handshake.
//  When CLEAR=1 it writes zero back to each bin as it reads it, so the RAM is empty
//  for the next frame.
// PARAMETERS
//  NB        8    RAM address width; PIXELS*BINS <= 2**NB
//  CW        8    bin count width (matches histogram count width)
//  BINS      64   bins per pixel histogram
//  PIXELS    4    pixel histograms stored per RAM
//  MIN_COUNT 2    peak count below this value reports peak_hit=0
//  CLEAR     1    1: zero each bin after reading it; 0: RAM left untouched
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  res        in   1     synchronous reset, active-high
//  start      in   1     1-cycle pulse: begin sweep; ignored while busy=1
//  busy       out  1     high from the cycle after start until done
//  done       out  1     1-cycle pulse after the last pixel result is accepted
//  ram_raddr  out  NB    RAM read address (port b)
//  ram_ren    out  1     RAM read enable
//  ram_rdata  in   CW    RAM read data, valid 1 cycle after ram_ren
//  ram_waddr  out  NB    RAM clear address (port a)
//  ram_wen    out  1     RAM write enable (clear)
//  ram_wdata  out  CW    always 0
//  peak_valid out  1     result valid; held until peak_ready
//  peak_ready in   1     consumer accepts the result
//  peak_pixel out  log2(PIXELS)  pixel index of the result
//  peak_bin   out  log2(BINS)    bin index of the maximum
//  peak_count out  CW    count at peak_bin
//  peak_hit   out  1     1 when peak_count >= MIN_COUNT
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0; the FSM returns to IDLE.
//  - Reset wins over every other input in the same cycle.
//  States IDLE -> SCAN -> DRAIN -> EMIT -> (SCAN | FIN) -> IDLE.
//  IDLE:
//  - On start: pixel p=0, bin b=0, max=0, max_bin=0, busy=1.
//  SCAN:
//  - One read per cycle: ram_ren=1, ram_raddr = p*BINS + b, b increments.
//  - After b = BINS-1 is issued, go to DRAIN.
//  Data return (every cycle in which rdata is valid, i.e. 1 cycle after ram_ren):
//  - If rdata > max (strict), update max and max_bin; ties keep the lowest bin.
//  - If CLEAR=1, the same cycle drives ram_wen=1 and ram_waddr = the registered
//    read address, so each address is written exactly once, after its read.
//  DRAIN:
//  - One cycle to absorb the final rdata; no new read is issued.
//  EMIT:
//  - peak_valid=1 with pixel, bin, count and hit all stable until peak_ready=1.
//  - On acceptance: p increments, max and max_bin are reset, and the FSM enters
//    SCAN, or FIN if p was PIXELS-1.
//  - No RAM access occurs while waiting for peak_ready (backpressure stalls the sweep).
//  FIN:
//  - done=1 for one cycle, busy=0, then IDLE.
//  Timing:
//  - Per-pixel latency from the first read to peak_valid is BINS+2 cycles.
//  - With peak_ready held at 1, the sweep takes PIXELS*(BINS+3)+1 cycles.
//  Boundary behaviour:
//  - All-zero histogram gives bin 0, count 0, hit 0.
//  - A count of all-ones (2**CW-1) is compared unsigned; there is no overflow, since
//    no arithmetic is done on counts.
//  - Address is p*BINS+b with no wrap; the last address is PIXELS*BINS-1.
//  - peak_ready high while peak_valid=0 has no effect.
//  - res during SCAN leaves RAM partially cleared; the histogram builder
//    re-initialises the RAM after reset.
// TESTING
//  1. Pixel 0: bin 17=42, all other bins 0 -> peak_pixel=0, peak_bin=17,
//     peak_count=42, peak_hit=1.
//  2. Bins 5 and 9 both =30, rest <30 -> peak_bin=5, peak_count=30.
//  3. All bins 0 (MIN_COUNT=2) -> peak_bin=0, peak_count=0, peak_hit=0;
//     bin max=1 -> peak_hit=0; bin max=2 -> peak_hit=1.
//  4. peak_ready low for 10 cycles on pixel 1 -> peak_valid and data held stable,
//     ram_ren=ram_wen=0 throughout; sweep resumes with addr 128 after acceptance.
//  5. Full sweep with ready=1 -> done exactly once, at cycle 4*67+1=269 after start.
//     Each of addresses 0..255 is read once, then written 0 once. Readback is all 0.
//     A start pulse while busy is ignored.
//  6. res=1 asserted mid-SCAN -> all outputs 0 on the next edge. A new start then
//     reads addr 0 first and produces correct results.

Source files
------------

// File: rtl/sifh_peak_scan.sv
// Sweeps every pixel histogram in the RAM, reports the peak bin and count per pixel
// over valid/ready, and optionally zeroes each bin right after it has been read.
module sifh_peak_scan #(
    parameter int NB        = 8,
    parameter int CW        = 8,
    parameter int BINS      = 64,
    parameter int PIXELS    = 4,
    parameter int MIN_COUNT = 2,
    parameter int CLEAR     = 1,
    localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int BW = (BINS > 1) ? $clog2(BINS) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [NB-1:0] ram_raddr,
    output logic          ram_ren,
    input  logic [CW-1:0] ram_rdata,
    output logic [NB-1:0] ram_waddr,
    output logic          ram_wen,
    output logic [CW-1:0] ram_wdata,
    output logic          peak_valid,
    input  logic          peak_ready,
    output logic [PW-1:0] peak_pixel,
    output logic [BW-1:0] peak_bin,
    output logic [CW-1:0] peak_count,
    output logic          peak_hit
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        EMIT,
        FIN
    } state_t;

    state_t        state;
    logic [PW-1:0] p;
    logic [BW-1:0] b;
    logic          rvalid;
    logic [BW-1:0] rbin;
    logic [CW-1:0] max;
    logic [BW-1:0] max_bin;

    assign ram_wdata = '0;

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            p          <= '0;
            b          <= '0;
            rvalid     <= 1'b0;
            rbin       <= '0;
            max        <= '0;
            max_bin    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_raddr  <= '0;
            ram_ren    <= 1'b0;
            ram_waddr  <= '0;
            ram_wen    <= 1'b0;
            peak_valid <= 1'b0;
            peak_pixel <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
            peak_hit   <= 1'b0;
        end else begin
            // Read data returns one cycle after ram_ren; the clear write trails it by the same cycle.
            rvalid    <= ram_ren;
            rbin      <= b;
            ram_wen   <= ram_ren && (CLEAR != 0);
            ram_waddr <= ram_raddr;

            if (rvalid && (ram_rdata > max)) begin
                max     <= ram_rdata;
                max_bin <= rbin;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        p         <= '0;
                        b         <= '0;
                        max       <= '0;
                        max_bin   <= '0;
                        ram_ren   <= 1'b1;
                        ram_raddr <= '0;
                    end
                end
                SCAN: begin
                    if (b == BW'(BINS - 1)) begin
                        ram_ren <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        b         <= b + BW'(1);
                        ram_raddr <= ram_raddr + NB'(1);
                        ram_ren   <= 1'b1;
                    end
                end
                DRAIN: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (!peak_valid) begin
                        peak_valid <= 1'b1;
                        peak_pixel <= p;
                        peak_bin   <= max_bin;
                        peak_count <= max;
                        peak_hit   <= (max >= CW'(MIN_COUNT));
                    end else if (peak_ready) begin
                        peak_valid <= 1'b0;
                        max        <= '0;
                        max_bin    <= '0;
                        if (p == PW'(PIXELS - 1)) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // ram_raddr still holds the previous pixel's last bin address.
                            state     <= SCAN;
                            p         <= p + PW'(1);
                            b         <= '0;
                            ram_ren   <= 1'b1;
                            ram_raddr <= ram_raddr + NB'(1);
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sifh_peak_scan.sv
// Scoreboard bench for sifh_peak_scan: a RAM model feeds the sweep, a monitor pops
// expected per-pixel results on every accepted handshake.
module tb_sifh_peak_scan;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] ram_raddr;
    logic       ram_ren;
    logic [7:0] ram_rdata;
    logic [7:0] ram_waddr;
    logic       ram_wen;
    logic [7:0] ram_wdata;
    logic       peak_valid;
    logic       peak_ready;
    logic [1:0] peak_pixel;
    logic [5:0] peak_bin;
    logic [7:0] peak_count;
    logic       peak_hit;

    sifh_peak_scan #(
        .NB(8), .CW(8), .BINS(64), .PIXELS(4), .MIN_COUNT(2), .CLEAR(1)
    ) dut (
        .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
        .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
        .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
        .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pixel(peak_pixel),
        .peak_bin(peak_bin), .peak_count(peak_count), .peak_hit(peak_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pixel;
        logic [5:0] bin;
        logic [7:0] count;
        logic       hit;
    } result_t;

    result_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int order_err = 0;

    logic [7:0] img [256];
    logic [7:0] mem [256];
    int rd_cnt [256];
    int wr_cnt [256];
    logic load = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read on port b, write on port a; load copies a new frame.
    always @(posedge clk) begin
        if (load) begin
            mem <= img;
            for (int i = 0; i < 256; i++) begin
                rd_cnt[i] = 0;
                wr_cnt[i] = 0;
            end
            order_err = 0;
        end else begin
            if (ram_ren) begin
                ram_rdata <= mem[ram_raddr];
                rd_cnt[ram_raddr]++;
            end
            if (ram_wen) begin
                mem[ram_waddr] <= ram_wdata;
                if (rd_cnt[ram_waddr] == 0) order_err++;
                wr_cnt[ram_waddr]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!res && peak_valid && peak_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual=pixel%0d bin%0d expected=none", peak_pixel, peak_bin);
            end else begin
                result_t e;
                e = q.pop_front();
                check("pixel", 32'(peak_pixel), 32'(e.pixel));
                check("bin",   32'(peak_bin),   32'(e.bin));
                check("count", 32'(peak_count), 32'(e.count));
                check("hit",   32'(peak_hit),   32'(e.hit));
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int pix, input int bin, input int cnt, input int hit);
        q.push_back({2'(pix), 6'(bin), 8'(cnt), 1'(hit)});
    endtask

    task automatic fill(input int f);
        for (int a = 0; a < 256; a++) begin
            int p, b, v;
            p = a / 64;
            b = a % 64;
            v = 0;
            case (f)
                0: case (p)
                    0: v = (b == 17) ? 42 : 0;
                    1: v = (b == 5 || b == 9) ? 30 : b % 20;
                    2: v = 0;
                    default: v = (b == 40) ? 1 : 0;
                endcase
                1: case (p)
                    0: v = (b == 63) ? 255 : 200;
                    1: v = (b == 0) ? 2 : 0;
                    2: v = b;
                    default: v = (b == 30 || b == 31) ? 7 : 6;
                endcase
                default: case (p)
                    0: v = (b == 0) ? 9 : 0;
                    1: v = (b == 63) ? 128 : ((b == 62) ? 127 : 0);
                    2: v = (b == 1) ? 2 : 0;
                    default: v = 1;
                endcase
            endcase
            img[a] = 8'(v);
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                at = cyc - start_cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_cond_valid_pixel(input int pix, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (peak_valid && (pix < 0 || peak_pixel == 2'(pix))) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_ren(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (ram_ren) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    initial begin
        int at;
        bit ok;
        int dc0;
        int bad_rd, bad_wr, bad_mem;
        bit seen;

        res = 1'b1;
        start = 1'b0;
        peak_ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {busy, done, ram_raddr, ram_ren, ram_waddr, ram_wen, peak_valid,
               peak_pixel, peak_bin, peak_count, peak_hit}, '0);
        res = 1'b0;
        tick();
        check("wdata_zero", 32'(ram_wdata), 0);

        // Frame A: isolated peak, tie, all-zero, below threshold; stall on pixel 1.
        fill(0);
        do_load();
        push(0, 17, 42, 1);
        push(1, 5, 30, 1);
        push(2, 0, 0, 0);
        push(3, 40, 1, 0);
        do_start();
        check("busy_after_start", 32'(busy), 1);
        wait_cond_valid_pixel(0, 200, ok);
        check("pixel0_valid_seen", 32'(ok), 1);
        tick();
        peak_ready = 1'b0;
        wait_cond_valid_pixel(1, 200, ok);
        check("pixel1_valid_seen", 32'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hold",
                  {peak_valid, ram_ren, ram_wen, peak_pixel, peak_bin, peak_count, peak_hit},
                  {1'b1, 1'b0, 1'b0, 2'd1, 6'd5, 8'd30, 1'b1});
            tick();
        end
        peak_ready = 1'b1;
        tick();
        wait_ren(5, ok);
        check("resume_ren", 32'(ok), 1);
        check("resume_addr", 32'(ram_raddr), 128);
        wait_done(600, at);
        check("done_cycle_stalled", at, 279);
        tick();
        check("queue_empty_a", q.size(), 0);

        // Frame B: all-ones count, threshold boundary, full timing, ignored start.
        fill(1);
        do_load();
        push(0, 63, 255, 1);
        push(1, 0, 2, 1);
        push(2, 63, 63, 1);
        push(3, 30, 7, 1);
        dc0 = done_cnt;
        do_start();
        seen = 1'b0;
        for (int k = 1; k < 400; k++) begin
            start = (k == 100);
            if (done && !seen) begin
                seen = 1'b1;
                check("done_cycle", cyc - start_cyc, 269);
            end
            tick();
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("done_once", done_cnt - dc0, 1);
        check("idle_after_sweep", 32'(busy), 0);
        bad_rd = 0;
        bad_wr = 0;
        bad_mem = 0;
        for (int a = 0; a < 256; a++) begin
            if (rd_cnt[a] != 1) bad_rd++;
            if (wr_cnt[a] != 1) bad_wr++;
            if (mem[a] != 8'd0) bad_mem++;
        end
        check("reads_once", bad_rd, 0);
        check("writes_once", bad_wr, 0);
        check("readback_zero", bad_mem, 0);
        check("write_after_read", order_err, 0);
        check("queue_empty_b", q.size(), 0);

        // Reset mid-scan, then a clean sweep.
        fill(0);
        do_load();
        do_start();
        repeat (20) tick();
        res = 1'b1;
        tick();
        check("midscan_reset_outputs",
              {busy, done, ram_raddr, ram_ren, ram_waddr, ram_wen, peak_valid,
               peak_pixel, peak_bin, peak_count, peak_hit}, '0);
        res = 1'b0;
        q.delete();
        fill(2);
        do_load();
        push(0, 0, 9, 1);
        push(1, 63, 128, 1);
        push(2, 1, 2, 1);
        push(3, 0, 1, 0);
        do_start();
        wait_ren(5, ok);
        check("restart_ren", 32'(ok), 1);
        check("restart_addr", 32'(ram_raddr), 0);
        wait_done(600, at);
        check("done_cycle_restart", at, 269);
        tick();
        check("queue_empty_c", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
